wr_fram_pack_buf: RTL and testbench
===================================

// Module: wr_fram_pack_buf
// PURPOSE
//  Parametrised frame write buffer between the video capture path and the DDR write master.
//  Packs IN_W-bit pixel words into OUT_W-bit memory words and stores them in NUM_BANKS round-robin burst banks.
//  Hands each full (or EOF-closed) bank to the DDR writer through a ready/done handshake, with 1-cycle read latency.
//  Drops and counts input words on overflow, where the single-bank asymmetric RAM had no flow control.
// PARAMETERS
//  IN_W       32   input word width; OUT_W/IN_W = RATIO, power of 2, >=1
//  OUT_W      128  packed memory word width
//  BURST_LEN  16   output words per bank, power of 2, >=2
//  NUM_BANKS  2    bank count, 2 or 4
//  (derived) AW=clog2(BURST_LEN), LEN_W=AW+1, FW=clog2(NUM_BANKS)+1
// PORTS
//  wr_clk      in   1      single clock for all logic
//  tb_wr_rst   in   1      reset, asynchronous, active-high
//  in_valid    in   1      input word strobe
//  in_data     in   IN_W   input word
//  in_eof      in   1      qualifies last word of frame (valid only with in_valid)
//  bank_rdy    out  1      oldest closed bank is available to read
//  bank_len    out  LEN_W  word count of that bank, 1..BURST_LEN
//  bank_last   out  1      that bank was closed by in_eof
//  rd_en       in   1      read strobe
//  rd_addr     in   AW     word address within oldest closed bank
//  rd_data     out  OUT_W  read data, registered
//  bank_done   in   1      releases oldest closed bank
//  fill_level  out  FW     number of closed banks, 0..NUM_BANKS
//  overflow    out  1      sticky, set on first dropped word
//  drop_cnt    out  16     dropped input words, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0; lane, word, write-bank and read-bank pointers 0; fill_level 0; RAM contents not cleared.
//  Packing:
//   - Lane counter runs 0..RATIO-1; lane k occupies bits [k*IN_W +: IN_W] (first word in LSBs).
//   - Lanes 0..RATIO-2 are held in a pack register.
//   - On the in_valid edge with lane==RATIO-1 or in_eof, {in_data, pack reg} is written to RAM[wbank*BURST_LEN+wptr].
//   - Lanes above the current one are written as zero; lane counter returns to 0; wptr increments.
//  Bank close, on the same edge as the commit, when wptr==BURST_LEN-1 or in_eof:
//   - Store per-bank len = wptr+1 and last = in_eof.
//   - wbank = (wbank+1) mod NUM_BANKS; wptr = 0; fill_level +1.
//  Accept rule: an input is accepted iff fill_level < NUM_BANKS.
//   - Otherwise the word is dropped: overflow<=1, drop_cnt+1 (saturating), pointers unchanged, in_eof ignored.
//   - No partial pack can exist while full, because the open bank closes before fill_level reaches NUM_BANKS.
//  Read side:
//   - bank_rdy = (fill_level != 0).
//   - bank_len and bank_last are the stored values of rbank; they read 0 when bank_rdy==0.
//   - rd_en at edge N: rd_data = RAM[rbank*BURST_LEN+rd_addr] after edge N; rd_data holds otherwise.
//   - rd_addr >= bank_len returns unspecified data and has no side effect.
//   - rd_en with bank_rdy==0 is ignored; rd_data holds.
//  Release: bank_done with bank_rdy==1 advances rbank (mod NUM_BANKS) and decrements fill_level.
//   - bank_done with bank_rdy==0 is ignored.
//  Simultaneous close + bank_done: fill_level unchanged, both pointers advance.
//   - If fill_level==NUM_BANKS on that edge, the input on the same edge is still dropped (accept uses pre-edge level).
//  Latency: a bank closed at edge N shows bank_rdy=1 in cycle N+1; rd_data is valid 1 cycle after rd_en.
//  Reset mid-operation: a partial pack and open-bank data are discarded; the next input starts at lane 0, bank 0.
// TESTING
//  1 Reset: assert tb_wr_rst after 40 inputs, mid-bank -> every output 0; first word after release goes to bank0 word0 lane0.
//  2 Fill (defaults): 64 words FFFFFFFF downward -> bank_rdy=1, bank_len=16, bank_last=0; rd_addr 0 -> FFFFFFFC_FFFFFFFD_FFFFFFFE_FFFFFFFF.
//  3 EOF: 6 words A0..A5, in_eof on A5 -> bank_len=2, bank_last=1; rd_addr 1 -> {64'h0, A5, A4}.
//  4 Overflow: no bank_done, 131 words -> fill_level=2, overflow=1, drop_cnt=3; bank_done -> fill_level=1, next word accepted into bank0.
//  5 Close on the same edge as bank_done, fill_level=1 -> fill_level stays 1, rbank=1, bank_len follows bank1.
//  6 IN_W=OUT_W=128, BURST_LEN=4, NUM_BANKS=4: 16 words -> fill_level=4, each bank_len=4, data in input order.

Source files
------------

// File: rtl/wr_fram_pack_buf.sv
// Frame write buffer: packs IN_W pixel words into OUT_W memory words across
// NUM_BANKS round-robin burst banks handed to the DDR writer via ready/done.
module wr_fram_pack_buf #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 128,
    parameter int BURST_LEN = 16,
    parameter int NUM_BANKS = 2,
    localparam int AW       = $clog2(BURST_LEN),
    localparam int LEN_W    = AW + 1,
    localparam int FW       = $clog2(NUM_BANKS) + 1
) (
    input  logic             wr_clk,
    input  logic             tb_wr_rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_eof,
    output logic             bank_rdy,
    output logic [LEN_W-1:0] bank_len,
    output logic             bank_last,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [OUT_W-1:0] rd_data,
    input  logic             bank_done,
    output logic [FW-1:0]    fill_level,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);

    localparam int RATIO = OUT_W / IN_W;
    localparam int LNW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int BW    = $clog2(NUM_BANKS);
    localparam int DEPTH = NUM_BANKS * BURST_LEN;

    logic [LNW-1:0]       lane;
    logic [OUT_W-1:0]     pack_q;
    logic [OUT_W-1:0]     commit_word;
    logic [AW-1:0]        wptr;
    logic [BW-1:0]        wbank;
    logic [BW-1:0]        rbank;
    logic [FW-1:0]        fill_q;
    logic [LEN_W-1:0]     len_q [NUM_BANKS];
    logic [NUM_BANKS-1:0] last_q;
    logic [OUT_W-1:0]     mem [DEPTH];

    logic accept, lane_last, commit, close_b, release_b;

    assign accept    = in_valid && (fill_q < FW'(NUM_BANKS));
    assign lane_last = (lane == LNW'(RATIO - 1));
    assign commit    = accept && (lane_last || in_eof);
    assign close_b   = commit && ((wptr == AW'(BURST_LEN - 1)) || in_eof);
    assign release_b = bank_done && (fill_q != '0);

    assign bank_rdy   = (fill_q != '0);
    assign bank_len   = bank_rdy ? len_q[rbank] : '0;
    assign bank_last  = bank_rdy ? last_q[rbank] : 1'b0;
    assign fill_level = fill_q;

    // Lanes above the current one are zeroed so an EOF-short word never carries stale pixels.
    always_comb begin
        commit_word = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (LNW'(k) < lane)
                commit_word[k*IN_W +: IN_W] = pack_q[k*IN_W +: IN_W];
            else if (LNW'(k) == lane)
                commit_word[k*IN_W +: IN_W] = in_data;
        end
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            lane   <= '0;
            pack_q <= '0;
            wptr   <= '0;
            wbank  <= '0;
        end else if (accept) begin
            if (commit) begin
                lane <= '0;
                wptr <= close_b ? '0 : wptr + 1'b1;
                if (close_b)
                    wbank <= wbank + 1'b1;
            end else begin
                lane <= lane + 1'b1;
                for (int unsigned k = 0; k < RATIO; k++)
                    if (LNW'(k) == lane)
                        pack_q[k*IN_W +: IN_W] <= in_data;
            end
        end
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++)
                len_q[b] <= '0;
            last_q <= '0;
        end else if (close_b) begin
            len_q[wbank]  <= LEN_W'(wptr) + LEN_W'(1);
            last_q[wbank] <= in_eof;
        end
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            fill_q <= '0;
            rbank  <= '0;
        end else begin
            if (release_b)
                rbank <= rbank + 1'b1;
            if (close_b && !release_b)
                fill_q <= fill_q + 1'b1;
            else if (!close_b && release_b)
                fill_q <= fill_q - 1'b1;
        end
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (in_valid && !accept) begin
            overflow <= 1'b1;
            if (drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (commit)
            mem[{wbank, wptr}] <= commit_word;
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst)
            rd_data <= '0;
        else if (rd_en && bank_rdy)
            rd_data <= mem[{rbank, rd_addr}];
    end

endmodule

// File: tb/tb_wr_fram_pack_buf.sv
// Directed bench for wr_fram_pack_buf: default 32->128 packing instance plus a
// 128-bit, 4-bank, burst-4 instance.
module tb_wr_fram_pack_buf;

    logic         wr_clk = 1'b0;
    logic         tb_wr_rst = 1'b1;

    logic         in_valid = 1'b0, in_eof = 1'b0, rd_en = 1'b0, bank_done = 1'b0;
    logic [31:0]  in_data = '0;
    logic [3:0]   rd_addr = '0;
    logic         bank_rdy, bank_last, overflow;
    logic [4:0]   bank_len;
    logic [127:0] rd_data;
    logic [1:0]   fill_level;
    logic [15:0]  drop_cnt;

    logic         in_valid6 = 1'b0, in_eof6 = 1'b0, rd_en6 = 1'b0, bank_done6 = 1'b0;
    logic [127:0] in_data6 = '0;
    logic [1:0]   rd_addr6 = '0;
    logic         bank_rdy6, bank_last6, overflow6;
    logic [2:0]   bank_len6;
    logic [127:0] rd_data6;
    logic [2:0]   fill_level6;
    logic [15:0]  drop_cnt6;

    int checks = 0;
    int errors = 0;

    always #5 wr_clk = ~wr_clk;

    wr_fram_pack_buf dut (
        .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst),
        .in_valid(in_valid), .in_data(in_data), .in_eof(in_eof),
        .bank_rdy(bank_rdy), .bank_len(bank_len), .bank_last(bank_last),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .bank_done(bank_done), .fill_level(fill_level),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    wr_fram_pack_buf #(.IN_W(128), .OUT_W(128), .BURST_LEN(4), .NUM_BANKS(4)) dut6 (
        .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst),
        .in_valid(in_valid6), .in_data(in_data6), .in_eof(in_eof6),
        .bank_rdy(bank_rdy6), .bank_len(bank_len6), .bank_last(bank_last6),
        .rd_en(rd_en6), .rd_addr(rd_addr6), .rd_data(rd_data6),
        .bank_done(bank_done6), .fill_level(fill_level6),
        .overflow(overflow6), .drop_cnt(drop_cnt6)
    );

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] exp;
    } rd_vec_t;

    rd_vec_t vec [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic e, input logic done);
        in_valid = v; in_data = d; in_eof = e; bank_done = done;
        @(posedge wr_clk); #1;
        in_valid = 1'b0; in_eof = 1'b0; bank_done = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_en = 1'b1; rd_addr = a;
        @(posedge wr_clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        tb_wr_rst = 1'b1;
        @(posedge wr_clk); #1;
        tb_wr_rst = 1'b0;
    endtask

    initial begin
        vec[0] = '{4'd0,  128'hFFFFFFFC_FFFFFFFD_FFFFFFFE_FFFFFFFF};
        vec[1] = '{4'd1,  128'hFFFFFFF8_FFFFFFF9_FFFFFFFA_FFFFFFFB};
        vec[2] = '{4'd7,  128'hFFFFFFE0_FFFFFFE1_FFFFFFE2_FFFFFFE3};
        vec[3] = '{4'd15, 128'hFFFFFFC0_FFFFFFC1_FFFFFFC2_FFFFFFC3};

        repeat (2) @(posedge wr_clk);
        #1 tb_wr_rst = 1'b0;

        // 1: reset mid-bank
        for (int i = 0; i < 40; i++) step(1'b1, 32'h1000 + i, 1'b0, 1'b0);
        #2 tb_wr_rst = 1'b1;
        #1;
        chk("rst_bank_rdy", bank_rdy, 0);
        chk("rst_bank_len", bank_len, 0);
        chk("rst_bank_last", bank_last, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_ovf_drop", {overflow, drop_cnt}, 0);
        chk("rst_rd_data", rd_data, 0);
        @(posedge wr_clk); #1 tb_wr_rst = 1'b0;
        step(1'b1, 32'h0000_1234, 1'b1, 1'b0);
        chk("rst_after_len", bank_len, 1);
        rd(4'd0);
        chk("rst_after_data", rd_data, 128'h1234);

        // 2: fill one bank with descending words
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 32'hFFFF_FFFF - i, 1'b0, 1'b0);
        chk("fill_rdy", bank_rdy, 1);
        chk("fill_len", bank_len, 16);
        chk("fill_last", bank_last, 0);
        chk("fill_level", fill_level, 1);
        for (int i = 0; i < 4; i++) begin
            rd(vec[i].addr);
            chk($sformatf("fill_rd_%0d", vec[i].addr), rd_data, vec[i].exp);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        chk("fill_released", {bank_rdy, fill_level, bank_len}, 0);
        rd(4'd0);
        chk("rd_when_empty_holds", rd_data, vec[3].exp);

        // 3: EOF-short bank
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 32'hA0 + i, (i == 5), 1'b0);
        chk("eof_len", bank_len, 2);
        chk("eof_last", bank_last, 1);
        rd(4'd1);
        chk("eof_rd1", rd_data, 128'h00000000_00000000_000000A5_000000A4);
        rd(4'd0);
        chk("eof_rd0", rd_data, 128'h000000A3_000000A2_000000A1_000000A0);

        // 4: overflow, release on a drop edge, then accept into bank0
        do_reset();
        for (int i = 0; i < 131; i++) step(1'b1, 32'h2000 + i, 1'b0, 1'b0);
        chk("ovf_fill", fill_level, 2);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_cnt, 3);
        step(1'b1, 32'hDEAD, 1'b1, 1'b1);
        chk("ovf_drop_on_done", drop_cnt, 4);
        chk("ovf_fill_after_done", fill_level, 1);
        chk("ovf_bank1_len", {bank_last, bank_len}, {1'b0, 5'd16});
        step(1'b1, 32'h55, 1'b1, 1'b0);
        chk("ovf_accept_fill", fill_level, 2);
        chk("ovf_accept_drop", drop_cnt, 4);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_bank0_len", {bank_last, bank_len}, {1'b1, 5'd1});
        rd(4'd0);
        chk("ovf_bank0_data", rd_data, 128'h55);

        // 5: close and release on the same edge
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 32'h0 + i, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0);
        chk("sim_fill_before", fill_level, 1);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        chk("sim_fill", fill_level, 1);
        chk("sim_bank1", {bank_last, bank_len}, {1'b1, 5'd2});
        rd(4'd1);
        chk("sim_rd1", rd_data, 128'h200);
        rd(4'd0);
        chk("sim_rd0", rd_data, 128'h00000103_00000102_00000101_00000100);

        // 6: 128-bit, 4 banks of 4
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid6 = 1'b1; in_data6 = 128'(i + 1);
            @(posedge wr_clk); #1;
        end
        in_valid6 = 1'b0;
        chk("b4_fill", fill_level6, 4);
        chk("b4_ovf", {overflow6, drop_cnt6}, 0);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("b4_len_%0d", b), {bank_last6, bank_len6}, {1'b0, 3'd4});
            for (int a = 0; a < 4; a++) begin
                rd_en6 = 1'b1; rd_addr6 = 2'(a);
                @(posedge wr_clk); #1;
                rd_en6 = 1'b0;
                chk($sformatf("b4_rd_%0d_%0d", b, a), rd_data6, 128'(4 * b + a + 1));
            end
            bank_done6 = 1'b1;
            @(posedge wr_clk); #1;
            bank_done6 = 1'b0;
        end
        chk("b4_empty", {bank_rdy6, fill_level6}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
